ra_builder: RTL and testbench

Writes a Region Array into VRAM at the end of TA list building, producing the per-tile entries that the region array parser later walks. On `start` it emits, in row-major tile order, one entry per tile: a control word, then one object-list pointer per list type. The pointers assume a fixed contiguous per-list OPB allocation from `OL_BASE`. The block sits on the PVR VRAM arbiter as a write-only client alongside the TA.

---
 rtl/ra_builder.sv | 228 ++++++++++++++++++++++
 tb/tb_ra_builder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ra_builder.sv
// Region Array builder: after TA list building, writes one control word plus one
// OPB pointer per list type for every tile, in row-major order, to VRAM.
module ra_builder (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] REGION_BASE,
    input  logic [31:0] OL_BASE,
    input  logic [31:0] TA_ALLOC_CTRL,
    input  logic [31:0] FPU_PARAM_CFG,
    input  logic [31:0] TILE_CLIP,
    input  logic        no_zclear,
    input  logic        no_flush,
    input  logic        vram_wait,
    output logic        ra_vram_wr,
    output logic [23:0] ra_vram_addr,
    output logic [31:0] ra_vram_dout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] ctrl_word(input logic [5:0] x, input logic [3:0] y,
                                              input logic last, input logic nz, input logic nf);
        ctrl_word = {last, nz, 1'b0, nf, 14'd0, 2'b00, y, x, 2'b00};
    endfunction

    function automatic logic [23:0] list_size(input logic [1:0] opb, input logic [10:0] tiles);
        if (opb == 2'd0) begin
            list_size = 24'd0;
        end else begin
            list_size = {13'd0, tiles} << (3'd4 + {1'b0, opb});
        end
    endfunction

    function automatic logic [31:0] list_ptr(input logic [1:0] opb, input logic [23:0] base,
                                             input logic [9:0] tidx);
        logic [23:0] offs;
        offs = {14'd0, tidx} << (3'd4 + {1'b0, opb});
        if (opb == 2'd0) begin
            list_ptr = 32'h8000_0000;
        end else begin
            list_ptr = {8'h00, base + offs};
        end
    endfunction

    state_t           state_r, state_s;
    logic [23:0]      region_base_r, ol_base_r;
    logic [4:0][1:0]  opb_r;
    logic             v2_r;
    logic [5:0]       x_max_r;
    logic [3:0]       y_max_r;
    logic             no_zclear_r, no_flush_r;
    logic [4:0][23:0] base_r, base_s;
    logic [10:0]      tiles_s;
    logic [23:0]      acc_s;
    logic [5:0]       x_r, x_s;
    logic [3:0]       y_r, y_s;
    logic [2:0]       w_r, w_s;
    logic [9:0]       tidx_r, tidx_s;
    logic [31:0]      word_s;
    logic             accept_s, last_word_s, last_tile_s;
    logic             unused_s;

    assign unused_s = ^{REGION_BASE[31:24], OL_BASE[31:24], TA_ALLOC_CTRL[31:18],
                        TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                        TA_ALLOC_CTRL[3:2], FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                        TILE_CLIP[31:20], TILE_CLIP[15:6]};

    assign accept_s    = (state_r == S_WRITE) && ra_vram_wr && !vram_wait;
    assign last_word_s = (w_r == (v2_r ? 3'd5 : 3'd4));
    assign last_tile_s = (x_r == x_max_r) && (y_r == y_max_r);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_CALC;
                else       state_s = S_IDLE;
            end
            S_CALC:  state_s = S_WRITE;
            S_WRITE: begin
                if (accept_s && last_word_s && last_tile_s) state_s = S_DONE;
                else                                        state_s = S_WRITE;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Tile count and cumulative list bases; disabled lists add zero bytes
    always_comb begin
        tiles_s = ({5'd0, x_max_r} + 11'd1) * ({7'd0, y_max_r} + 11'd1);
        acc_s   = ol_base_r;
        base_s  = '0;
        for (int l = 0; l < 5; l++) begin
            base_s[l] = acc_s;
            acc_s     = acc_s + list_size(opb_r[l], tiles_s);
        end
    end

    // Next word position and the word presented after an accept
    always_comb begin
        x_s    = x_r;
        y_s    = y_r;
        w_s    = w_r;
        tidx_s = tidx_r;
        if (!last_word_s) begin
            w_s = w_r + 3'd1;
        end else if (x_r == x_max_r) begin
            w_s    = 3'd0;
            x_s    = 6'd0;
            y_s    = y_r + 4'd1;
            tidx_s = tidx_r + 10'd1;
        end else begin
            w_s    = 3'd0;
            x_s    = x_r + 6'd1;
            tidx_s = tidx_r + 10'd1;
        end
        case (w_s)
            3'd0:    word_s = ctrl_word(x_s, y_s, (x_s == x_max_r) && (y_s == y_max_r),
                                        no_zclear_r, no_flush_r);
            3'd1:    word_s = list_ptr(opb_r[0], base_r[0], tidx_s);
            3'd2:    word_s = list_ptr(opb_r[1], base_r[1], tidx_s);
            3'd3:    word_s = list_ptr(opb_r[2], base_r[2], tidx_s);
            3'd4:    word_s = list_ptr(opb_r[3], base_r[3], tidx_s);
            3'd5:    word_s = list_ptr(opb_r[4], base_r[4], tidx_s);
            default: word_s = 32'd0;
        endcase
    end

    // Config latch, position counters and registered VRAM outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            region_base_r <= 24'd0;
            ol_base_r     <= 24'd0;
            opb_r         <= '0;
            v2_r          <= 1'b0;
            x_max_r       <= 6'd0;
            y_max_r       <= 4'd0;
            no_zclear_r   <= 1'b0;
            no_flush_r    <= 1'b0;
            base_r        <= '0;
            x_r           <= 6'd0;
            y_r           <= 4'd0;
            w_r           <= 3'd0;
            tidx_r        <= 10'd0;
            ra_vram_wr    <= 1'b0;
            ra_vram_addr  <= 24'd0;
            ra_vram_dout  <= 32'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        region_base_r <= REGION_BASE[23:0];
                        ol_base_r     <= OL_BASE[23:0];
                        opb_r         <= {TA_ALLOC_CTRL[17:16], TA_ALLOC_CTRL[13:12],
                                          TA_ALLOC_CTRL[9:8], TA_ALLOC_CTRL[5:4],
                                          TA_ALLOC_CTRL[1:0]};
                        v2_r          <= FPU_PARAM_CFG[21];
                        x_max_r       <= TILE_CLIP[5:0];
                        y_max_r       <= TILE_CLIP[19:16];
                        no_zclear_r   <= no_zclear;
                        no_flush_r    <= no_flush;
                        x_r           <= 6'd0;
                        y_r           <= 4'd0;
                        w_r           <= 3'd0;
                        tidx_r        <= 10'd0;
                        busy          <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_CALC: begin
                    base_r       <= base_s;
                    ra_vram_wr   <= 1'b1;
                    ra_vram_addr <= region_base_r;
                    ra_vram_dout <= ctrl_word(6'd0, 4'd0, (x_max_r == 6'd0) && (y_max_r == 4'd0),
                                              no_zclear_r, no_flush_r);
                end
                S_WRITE: begin
                    if (!accept_s) begin
                        ra_vram_wr <= 1'b1;
                    end else if (last_word_s && last_tile_s) begin
                        ra_vram_wr <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        ra_vram_addr <= ra_vram_addr + 24'd4;
                        ra_vram_dout <= word_s;
                        x_r          <= x_s;
                        y_r          <= y_s;
                        w_r          <= w_s;
                        tidx_r       <= tidx_s;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    ra_vram_wr <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ra_builder.sv
// Bench for ra_builder: directed test-plan cases plus randomized configurations,
// checked word by word against a tile-loop reference model of the Region Array.
module tb_ra_builder;

    logic        clock = 1'b0;
    logic        reset, start, no_zclear, no_flush, vram_wait;
    logic [31:0] REGION_BASE, OL_BASE, TA_ALLOC_CTRL, FPU_PARAM_CFG, TILE_CLIP;
    logic        ra_vram_wr;
    logic [23:0] ra_vram_addr;
    logic [31:0] ra_vram_dout;
    logic        busy, done;

    int vectors     = 0;
    int miscompares = 0;
    int unsigned exp_addr[$];
    int unsigned exp_data[$];

    ra_builder dut (
        .clock(clock), .reset(reset), .start(start),
        .REGION_BASE(REGION_BASE), .OL_BASE(OL_BASE), .TA_ALLOC_CTRL(TA_ALLOC_CTRL),
        .FPU_PARAM_CFG(FPU_PARAM_CFG), .TILE_CLIP(TILE_CLIP),
        .no_zclear(no_zclear), .no_flush(no_flush), .vram_wait(vram_wait),
        .ra_vram_wr(ra_vram_wr), .ra_vram_addr(ra_vram_addr), .ra_vram_dout(ra_vram_dout),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected write stream: every tile in row-major order, ctrl word then list pointers
    task automatic build_model(input logic [31:0] rb, input logic [31:0] olb, input logic [31:0] alloc,
                               input logic [31:0] fpu, input logic [31:0] clip,
                               input logic nz, input logic nf);
        int unsigned xc, yc, n, nw, cum, addr, x, y, ctrl;
        int unsigned opb[5];
        int unsigned base[5];
        exp_addr.delete();
        exp_data.delete();
        xc  = 32'(clip[5:0]) + 32'd1;
        yc  = 32'(clip[19:16]) + 32'd1;
        n   = xc * yc;
        nw  = fpu[21] ? 32'd5 : 32'd4;
        cum = olb & 32'h00FF_FFFF;
        for (int l = 0; l < 5; l++) begin
            opb[l]  = (alloc >> (4 * l)) & 32'd3;
            base[l] = cum;
            if (opb[l] != 32'd0) cum = (cum + n * (32'd16 << opb[l])) & 32'h00FF_FFFF;
        end
        addr = rb & 32'h00FF_FFFF;
        for (int unsigned t = 0; t < n; t++) begin
            x    = t % xc;
            y    = t / xc;
            ctrl = ((t == n - 32'd1) ? 32'h8000_0000 : 32'd0) | (nz ? 32'h4000_0000 : 32'd0) |
                   (nf ? 32'h1000_0000 : 32'd0) | (y << 8) | (x << 2);
            exp_addr.push_back(addr);
            exp_data.push_back(ctrl);
            addr = (addr + 32'd4) & 32'h00FF_FFFF;
            for (int unsigned l = 0; l < nw; l++) begin
                exp_addr.push_back(addr);
                if (opb[l] == 32'd0) exp_data.push_back(32'h8000_0000);
                else exp_data.push_back((base[l] + t * (32'd16 << opb[l])) & 32'h00FF_FFFF);
                addr = (addr + 32'd4) & 32'h00FF_FFFF;
            end
        end
    endtask

    task automatic run_case(input logic [31:0] rb, input logic [31:0] olb, input logic [31:0] alloc,
                            input logic [31:0] fpu, input logic [31:0] clip,
                            input logic nz, input logic nf,
                            input int stall_word, input int stall_len, input bit stall_rand,
                            input int busy_start_at, input int abort_after,
                            input bit scramble, input bit done_start);
        int cyc, popped, stalls, stall_left, total;
        bit w;
        build_model(rb, olb, alloc, fpu, clip, nz, nf);
        total      = exp_addr.size();
        stall_left = stall_len;
        popped     = 0;
        stalls     = 0;
        @(negedge clock);
        REGION_BASE = rb; OL_BASE = olb; TA_ALLOC_CTRL = alloc;
        FPU_PARAM_CFG = fpu; TILE_CLIP = clip; no_zclear = nz; no_flush = nf;
        vram_wait = 1'b0;
        start = 1'b1;
        @(posedge clock);
        cyc = 1;
        @(negedge clock);
        start = 1'b0;
        if (scramble) begin
            REGION_BASE = $urandom(); OL_BASE = $urandom(); TA_ALLOC_CTRL = $urandom();
            FPU_PARAM_CFG = $urandom(); TILE_CLIP = $urandom();
            no_zclear = ~nz; no_flush = ~nf;
        end
        while (!done && cyc < 20000) begin
            if (abort_after >= 0 && popped == abort_after) begin
                reset = 1'b1;
                vram_wait = 1'b0;
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                check("rst_wr", {31'd0, ra_vram_wr}, 32'd0);
                check("rst_addr", {8'd0, ra_vram_addr}, 32'd0);
                check("rst_dout", ra_vram_dout, 32'd0);
                check("rst_busy_done", {30'd0, busy, done}, 32'd0);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clock);
                    @(negedge clock);
                    check("rst_no_done", {30'd0, done, ra_vram_wr}, 32'd0);
                end
                return;
            end
            check("busy_run", {31'd0, busy}, 32'd1);
            start = (cyc == busy_start_at);
            w = 1'b0;
            if (popped == stall_word && stall_left > 0) begin
                w = 1'b1;
                stall_left--;
            end else if (stall_rand && $urandom_range(0, 3) == 0) begin
                w = 1'b1;
            end
            vram_wait = w;
            if (ra_vram_wr) begin
                if (exp_addr.size() == 0) begin
                    check("wr_extra", {31'd0, ra_vram_wr}, 32'd0);
                end else begin
                    check("addr", {8'd0, ra_vram_addr}, exp_addr[0]);
                    check("data", ra_vram_dout, exp_data[0]);
                    if (w) begin
                        stalls++;
                    end else begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                        popped++;
                    end
                end
            end
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        start = 1'b0;
        vram_wait = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_cycle", cyc, 2 + total + stalls);
        check("words_left", exp_addr.size(), 32'd0);
        check("busy_wr_at_done", {30'd0, busy, ra_vram_wr}, 32'd0);
        if (done_start) start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("idle_after", {30'd0, busy, ra_vram_wr}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; no_zclear = 1'b0; no_flush = 1'b0; vram_wait = 1'b0;
        REGION_BASE = 32'd0; OL_BASE = 32'd0; TA_ALLOC_CTRL = 32'd0;
        FPU_PARAM_CFG = 32'd0; TILE_CLIP = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_wr", {31'd0, ra_vram_wr}, 32'd0);
        check("reset_addr", {8'd0, ra_vram_addr}, 32'd0);
        check("reset_dout", ra_vram_dout, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // v1, 2 tiles, O list only
        run_case(32'h1000, 32'h10_0000, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0,
                 -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
        // v2, 2x2 tiles, all lists opb=3; start while done is high
        run_case(32'h1000, 32'h10_0000, 32'h3_3333, 32'h0020_0000, 32'h1_0001, 1'b0, 1'b0,
                 -1, 0, 1'b0, -1, -1, 1'b0, 1'b1);
        // three-cycle stall on word 2
        run_case(32'h1000, 32'h10_0000, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0,
                 2, 3, 1'b0, -1, -1, 1'b0, 1'b0);
        // control flags and 24-bit address wrap
        run_case(32'h00FF_FFF8, 32'h10_0000, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1,
                 -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
        // reset after three accepted words, then a full restart
        run_case(32'h2000, 32'h20_0000, 32'h3_3333, 32'h0020_0000, 32'h1_0001, 1'b0, 1'b0,
                 -1, 0, 1'b0, -1, 3, 1'b0, 1'b0);
        run_case(32'h2000, 32'h20_0000, 32'h3_3333, 32'h0020_0000, 32'h1_0001, 1'b0, 1'b0,
                 -1, 0, 1'b0, -1, -1, 1'b0, 1'b0);
        // start pulse while busy, inputs changed while busy
        run_case(32'h3000, 32'h30_0000, 32'h1_2301, 32'h0020_0000, 32'h1_0002, 1'b1, 1'b0,
                 -1, 0, 1'b1, 6, -1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_case($urandom(), $urandom(), $urandom(), $urandom(),
                     ($urandom() & 32'hFFF0_FFC0) | (32'($urandom_range(0, 3)) << 16) |
                     32'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     -1, 0, 1'b1, -1, -1, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
